// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: queue entry layout, fetch states
// and the word imem returns outside its populated range.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_e;

    localparam logic [31:0] NOP_OOB = 32'h80000000;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer of PC-tagged instruction words; the head is read
// straight out of registered storage so it is stable while decode stalls.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output logic         full_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [OCC_W-1:0] count_q;

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign full_o  = (count_q == DEPTH_C);
    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, fills the prefetch queue from imem and
// stops at the end of populated memory until a redirect restarts it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_WORDS = 400,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_pc_o,
    input  logic [31:0]      imem_instr_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      instr_pc_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             valid;
    fetch_entry_t     wrEntry;
    fetch_entry_t     head;

    assign pop     = valid & instr_ready_i;
    assign wrEntry = '{pc: fetchPc_q, instr: imem_instr_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_RUN;
            fetchPc_q  <= RESET_PC;
            fetchCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            fetchCnt_q <= fetchCnt_d;
        end
    end

    // Redirect outranks everything; a push may reuse the slot freed by a same-cycle pop.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        fetchCnt_d = fetchCnt_q;
        push       = 1'b0;
        if (redirect_i) begin
            state_d   = FS_RUN;
            fetchPc_d = redirect_pc_i;
        end else if (state_q == FS_RUN) begin
            if (fetchPc_q >= IMEM_LIMIT) begin
                state_d = FS_HALTED;
            end else if (!full || pop) begin
                push      = 1'b1;
                fetchPc_d = fetchPc_q + 32'd1;
                if (fetchCnt_q != '1) begin
                    fetchCnt_d = fetchCnt_q + 1'b1;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop & ~redirect_i),
        .flush_i (redirect_i),
        .data_i  (wrEntry),
        .full_o  (full),
        .valid_o (valid),
        .head_o  (head)
    );

    assign imem_pc_o     = fetchPc_q;
    assign instr_valid_o = valid;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign halted_o      = (state_q == FS_HALTED);
    assign fetch_count_o = fetchCnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// ready/redirect traffic, compared against a queue-based model of the fetch stage.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH   = 4;
    localparam int          IMEM    = 24;
    localparam logic [31:0] IMEM_L  = 32'(IMEM);
    localparam logic [31:0] RST_PC  = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    int tests;
    int failed;

    logic [31:0] mPcQ[$];
    logic [31:0] mPc;
    logic        mHalted;
    logic [31:0] mCount;

    always #5 clk = ~clk;

    // Populated imem returns a PC-derived word; beyond it, the out-of-range NOP.
    assign imem_instr_i = (imem_pc_o < IMEM_L) ? 32'h1000_0000 + imem_pc_o : NOP_OOB;

    fetch_unit #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RST_PC),
        .IMEM_WORDS (IMEM),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .halted_o      (halted_o),
        .fetch_count_o (fetch_count_o)
    );

    task automatic modelReset();
        mPcQ.delete();
        mPc     = RST_PC;
        mHalted = 1'b0;
        mCount  = 32'd0;
    endtask

    task automatic modelStep(input logic rdy, input logic redir, input logic [31:0] rpc);
        bit popNow;
        popNow = (mPcQ.size() != 0) && rdy;
        if (redir) begin
            mPcQ.delete();
            mPc     = rpc;
            mHalted = 1'b0;
        end else begin
            if (popNow) begin
                void'(mPcQ.pop_front());
            end
            if (!mHalted) begin
                if (mPc >= IMEM_L) begin
                    mHalted = 1'b1;
                end else if (mPcQ.size() < DEPTH) begin
                    mPcQ.push_back(mPc);
                    mPc = mPc + 32'd1;
                    if (mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("instr_valid", 32'(instr_valid_o), (mPcQ.size() != 0) ? 32'd1 : 32'd0);
        check("halted", 32'(halted_o), 32'(mHalted));
        check("imem_pc", imem_pc_o, mPc);
        check("fetch_count", fetch_count_o, mCount);
        if (mPcQ.size() != 0) begin
            check("instr_pc", instr_pc_o, mPcQ[0]);
            check("instr", instr_o, 32'h1000_0000 + mPcQ[0]);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        modelStep(rdy, redir, rpc);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic        rdyR;
        logic        redirR;
        logic [31:0] rpcR;

        tests         = 0;
        failed        = 0;
        rst_n         = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        modelReset();
        #2;
        checkOutput();
        check("rst_instr", instr_o, 32'd0);
        check("rst_instr_pc", instr_pc_o, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Free-flowing decode: one instruction per cycle from pc 0.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Asynchronous reset between edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        check("async_rst_instr_pc", instr_pc_o, 32'd0);
        @(posedge clk);
        #1;
        checkOutput();
        #2 rst_n = 1'b1;

        // Stalled decode fills the queue, then drains without gaps.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        check("stall_fetch_pc", imem_pc_o, 32'd4);
        check("stall_head_pc", instr_pc_o, 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Fill with pcs 10..13, then redirect near the end of memory and run into halt.
        applyStimulus(1'b0, 1'b1, 32'd10);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        check("full_head_pc", instr_pc_o, 32'd10);
        applyStimulus(1'b1, 1'b1, IMEM_L - 32'd4);
        check("post_redirect_valid", 32'(instr_valid_o), 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        check("halted_end", 32'(halted_o), 32'd1);
        check("imem_pc_end", imem_pc_o, IMEM_L);

        // Redirect out of HALTED resumes delivery at pc 2.
        applyStimulus(1'b1, 1'b1, 32'd2);
        check("unhalt", 32'(halted_o), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0);

        // Random traffic, including redirects beyond populated memory.
        for (int i = 0; i < 400; i++) begin
            rdyR   = ($urandom_range(0, 3) != 0);
            redirR = ($urandom_range(0, 19) == 0);
            rpcR   = $urandom_range(0, IMEM + 3);
            applyStimulus(rdyR, redirR, rpcR);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly in front of the instruction memory (imem) and feeds the decode stage.
- Owns the fetch PC and drives imem's word-indexed pc input.
- Captures the combinational instruction word into a small prefetch queue tagged with its PC.
- Presents queue entries to decode over a valid/ready handshake.
- Handles control-flow redirects and halts cleanly when the PC leaves the populated memory range.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'd0, fetch PC loaded on reset
IMEM_WORDS, 400, number of populated imem words; fetch PC >= this halts fetch
CNT_W, 32, width of the fetched-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_pc_o  out  32  word index to imem, equals fetch_pc register
imem_instr_i  in  32  combinational instruction returned by imem for imem_pc_o
redirect_i  in  1  single-cycle redirect request (branch/jump/exception)
redirect_pc_i  in  32  new word-indexed fetch PC, sampled when redirect_i=1
instr_valid_o  out  1  queue head is valid
instr_ready_i  in  1  decode accepts head this cycle
instr_o  out  32  queue head instruction
instr_pc_o  out  32  PC of queue head
halted_o  out  1  fetch stopped at end of memory
fetch_count_o  out  CNT_W  instructions pushed since reset, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - fetch_pc=RESET_PC, queue empty, state=RUN.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, halted_o=0, fetch_count_o=0.
- States:
  - RUN: fetching.
  - HALTED: no pushes; fetch_pc is held; halted_o=1.
- Definitions: pop = instr_valid_o & instr_ready_i. full = count==DEPTH.
- Push condition in RUN: fetch_pc < IMEM_WORDS, no redirect this cycle, and (!full or pop).
  - Push writes {fetch_pc, imem_instr_i} at tail.
  - Then fetch_pc += 1 and fetch_count_o += 1, saturating at all-ones.
- RUN -> HALTED: at the edge where RUN has fetch_pc >= IMEM_WORDS and no redirect.
  - The out-of-range NOP word (32'h80000000) is never enqueued.
- Decode can drain the queue normally while HALTED.
- Latency:
  - imem_pc_o changes in the cycle after the edge that updates fetch_pc.
  - An instruction pushed at edge N is visible on instr_o/instr_valid_o after edge N if the queue was empty, because the head is registered storage.
  - First instr_valid_o=1 occurs one cycle after rst_n deasserts.
- Queue: circular buffer, log2(DEPTH)-bit pointers that wrap modulo DEPTH, plus an explicit count (0..DEPTH).
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Simultaneous push and pop when empty is not possible, because valid=0.
- Redirect (highest priority, valid in either state):
  - At the edge: queue flushed (count=0, pointers reset), fetch_pc=redirect_pc_i, state=RUN, halted_o=0.
  - No push and no counted pop occur in the redirect cycle.
  - instr_valid_o=0 in the following cycle; the first instruction from the new PC is valid one cycle after that.
  - Redirect to a PC >= IMEM_WORDS enters HALTED on the next edge.
- Holding rule: instr_o and instr_pc_o hold their values while instr_valid_o=1 and instr_ready_i=0.
- When instr_valid_o=0, instr_o/instr_pc_o are don't-care; the bench must not check them.
- Arithmetic: fetch_pc increments modulo 2^32, but halt occurs before any wrap because IMEM_WORDS < 2^32.
- Reset mid-operation asynchronously clears all state, regardless of queue contents.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - typedef enum fetch_state_e {FS_RUN, FS_HALTED}
  - localparam NOP_OOB = 32'h80000000
- Sub-module fetch_queue: parameterised DEPTH FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: full, head, valid.
- fetch_unit contains the PC register, state machine, counter and the queue instance.

Test Plan:
1. Reset with imem holding instr[k]=32'h1000_0000+k, instr_ready_i=1 constantly -> instr_pc_o goes 0,1,2,3... one per cycle from cycle 1; instr_o=32'h1000_0000+pc; fetch_count_o increments each cycle.
2. instr_ready_i=0 for 10 cycles from reset -> exactly DEPTH=4 pushes; fetch_pc=4; head holds pc 0 stable. Ready then raised -> pcs 0,1,2,3,4... delivered with no gap or duplicate.
3. IMEM_WORDS=8, ready=1 -> pcs 0..7 delivered; halted_o=1 from the cycle after fetch_pc reaches 8; 32'h80000000 never appears with instr_valid_o=1; fetch_count_o stays 8.
4. Redirect: queue full with pcs 10..13, pulse redirect_i with redirect_pc_i=100 -> instr_valid_o=0 next cycle, then head pc=100, 101...; pcs 10..13 never delivered after the redirect edge.
5. Redirect while HALTED with redirect_pc_i=2 -> halted_o=0 next cycle; delivery resumes at pc 2.
6. Assert rst_n=0 mid-stream for one cycle, asynchronously between edges -> instr_valid_o and halted_o drop immediately, fetch_count_o=0, imem_pc_o=RESET_PC; delivery restarts at pc 0 after release.
